// File: rtl/scene_renderer.sv
// scene_renderer: per-pixel RGB generator for the Vga controller.
// Game state is frozen once per frame at the last active pixel; colour appears two clocks after its address.
module scene_renderer #(
  parameter int DINO_X       = 64,
  parameter int DINO_W       = 32,
  parameter int DINO_H       = 40,
  parameter int GROUND_Y     = 400,
  parameter int GROUND_H     = 4,
  parameter int H_SCALE      = 2,
  parameter int BLINK_FRAMES = 16
) (
  input  logic        CLK,
  input  logic        clrn,
  input  logic [8:0]  row_addr,
  input  logic [9:0]  col_addr,
  input  logic        rdn,
  input  logic [5:0]  dinosaur_height,
  input  logic [5:0]  ground_position,
  input  logic        game_status,
  output logic [11:0] vga_data,
  output logic        frame_tick
);

  localparam int BLINK_BIT = $clog2(BLINK_FRAMES);

  logic       latch_cond;
  logic       latch_d;
  logic [5:0] hgt;
  logic [5:0] pos;
  logic       sts;
  logic [4:0] blink_cnt;
  logic       blink_on;

  logic [8:0] row_d;
  logic [9:0] col_d;
  logic       rdn_d;

  logic [9:0] row_w;
  logic [9:0] dino_top;
  logic [5:0] gnd_phase;
  logic       dino_hit;
  logic       gnd_hit;

  assign latch_cond = (row_addr == 9'd479) && (col_addr == 10'd639);
  assign blink_on   = blink_cnt[BLINK_BIT];

  // Snapshot loads only on the rising edge of latch_cond, so a stalled address cannot reload it.
  always_ff @(posedge CLK or negedge clrn) begin
    if (!clrn) begin
      latch_d    <= 1'b0;
      frame_tick <= 1'b0;
      hgt        <= 6'd0;
      pos        <= 6'd0;
      sts        <= 1'b0;
      blink_cnt  <= 5'd0;
    end else begin
      latch_d    <= latch_cond;
      frame_tick <= latch_cond && !latch_d;
      if (latch_cond && !latch_d) begin
        hgt <= dinosaur_height;
        pos <= ground_position;
        sts <= game_status;
      end
      if (frame_tick) begin
        blink_cnt <= sts ? 5'd0 : blink_cnt + 5'd1;
      end
    end
  end

  always_ff @(posedge CLK or negedge clrn) begin
    if (!clrn) begin
      row_d <= 9'd0;
      col_d <= 10'd0;
      rdn_d <= 1'b0;
    end else begin
      row_d <= row_addr;
      col_d <= col_addr;
      rdn_d <= rdn;
    end
  end

  // The ground pattern is a 64-px period stripe shifted by the scroll phase; the add wraps in 6 bits.
  always_comb begin
    row_w     = {1'b0, row_d};
    dino_top  = 10'(GROUND_Y - DINO_H - int'(hgt) * H_SCALE);
    gnd_phase = col_d[5:0] + pos;
    dino_hit  = (col_d >= 10'(DINO_X)) && (col_d < 10'(DINO_X + DINO_W)) &&
                (row_w >= dino_top) && (row_w < dino_top + 10'(DINO_H));
    gnd_hit   = (row_w >= 10'(GROUND_Y)) && (row_w < 10'(GROUND_Y + GROUND_H)) &&
                (gnd_phase < 6'd32);
  end

  always_ff @(posedge CLK or negedge clrn) begin
    if (!clrn) begin
      vga_data <= 12'h000;
    end else if (rdn_d) begin
      vga_data <= 12'h000;
    end else if (dino_hit) begin
      vga_data <= (!sts && blink_on) ? 12'hF00 : 12'h555;
    end else if (gnd_hit) begin
      vga_data <= 12'h333;
    end else begin
      vga_data <= 12'hFFF;
    end
  end

endmodule

// File: tb/tb_scene_renderer.sv
// Directed bench for scene_renderer: stimulus pushes expected pixels/ticks into queues,
// a negedge monitor pops and compares them on the cycle they are due.
module tb_scene_renderer;

  logic        CLK = 1'b0;
  logic        clrn;
  logic [8:0]  row_addr;
  logic [9:0]  col_addr;
  logic        rdn;
  logic [5:0]  dinosaur_height;
  logic [5:0]  ground_position;
  logic        game_status;
  logic [11:0] vga_data;
  logic        frame_tick;

  typedef struct {
    int          due;
    logic [11:0] val;
  } exp_t;

  exp_t pix_q[$];
  exp_t tick_q[$];
  exp_t mon_item;

  int cyc = 0;
  int err_count = 0;
  int chk_count = 0;

  scene_renderer dut (
    .CLK             (CLK),
    .clrn            (clrn),
    .row_addr        (row_addr),
    .col_addr        (col_addr),
    .rdn             (rdn),
    .dinosaur_height (dinosaur_height),
    .ground_position (ground_position),
    .game_status     (game_status),
    .vga_data        (vga_data),
    .frame_tick      (frame_tick)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [11:0] actual, input logic [11:0] expected);
    chk_count++;
    if (actual !== expected) begin
      err_count++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic push_tick(input int offset, input logic val);
    tick_q.push_back('{due: cyc + offset, val: {11'd0, val}});
  endtask

  // Drive one address for one clock; its colour is due two edges later.
  task automatic apply_stimulus(input logic [8:0] r, input logic [9:0] c, input logic rd,
                                input logic [11:0] exp_val, input bit chk);
    row_addr = r;
    col_addr = c;
    rdn      = rd;
    if (chk) pix_q.push_back('{due: cyc + 2, val: exp_val});
    step();
  endtask

  always @(negedge CLK) begin
    while (pix_q.size() > 0 && pix_q[0].due < cyc) begin
      mon_item = pix_q.pop_front();
      chk_count++;
      err_count++;
      $display("[TB] FAIL pixel_missed: due cycle %0d, now %0d", mon_item.due, cyc);
    end
    if (pix_q.size() > 0 && pix_q[0].due == cyc) begin
      mon_item = pix_q.pop_front();
      check_output($sformatf("pixel@%0d", cyc), vga_data, mon_item.val);
    end
    while (tick_q.size() > 0 && tick_q[0].due < cyc) begin
      mon_item = tick_q.pop_front();
      chk_count++;
      err_count++;
      $display("[TB] FAIL tick_missed: due cycle %0d, now %0d", mon_item.due, cyc);
    end
    if (tick_q.size() > 0 && tick_q[0].due == cyc) begin
      mon_item = tick_q.pop_front();
      check_output($sformatf("frame_tick@%0d", cyc), {11'd0, frame_tick}, mon_item.val);
    end
  end

  initial begin
    clrn            = 1'b0;
    row_addr        = 9'd0;
    col_addr        = 10'd0;
    rdn             = 1'b1;
    dinosaur_height = 6'd0;
    ground_position = 6'd0;
    game_status     = 1'b1;
    #12;
    check_output("reset_data", vga_data, 12'h000);
    check_output("reset_tick", {11'd0, frame_tick}, 12'h000);
    #10 clrn = 1'b1;
    step();

    // Latency and blanking
    apply_stimulus(9'd10, 10'd10, 1'b0, 12'hFFF, 1'b1);
    apply_stimulus(9'd10, 10'd10, 1'b1, 12'h000, 1'b1);
    apply_stimulus(9'd10, 10'd10, 1'b0, 12'hFFF, 1'b1);
    apply_stimulus(9'd10, 10'd10, 1'b1, 12'h000, 1'b1);

    // Latch hgt=0, pos=40, running
    game_status     = 1'b1;
    dinosaur_height = 6'd0;
    ground_position = 6'd40;
    push_tick(1, 1'b1);
    push_tick(2, 1'b0);
    apply_stimulus(9'd479, 10'd639, 1'b1, 12'h000, 1'b1);
    apply_stimulus(9'd380, 10'd64,  1'b0, 12'h555, 1'b1);
    apply_stimulus(9'd400, 10'd30,  1'b0, 12'h333, 1'b1);
    apply_stimulus(9'd400, 10'd60,  1'b0, 12'hFFF, 1'b1);
    apply_stimulus(9'd380, 10'd95,  1'b0, 12'h555, 1'b1);
    apply_stimulus(9'd380, 10'd96,  1'b0, 12'hFFF, 1'b1);
    apply_stimulus(9'd380, 10'd63,  1'b0, 12'hFFF, 1'b1);
    apply_stimulus(9'd360, 10'd64,  1'b0, 12'h555, 1'b1);
    apply_stimulus(9'd359, 10'd64,  1'b0, 12'hFFF, 1'b1);
    apply_stimulus(9'd399, 10'd64,  1'b0, 12'h555, 1'b1);
    apply_stimulus(9'd380, 10'd64,  1'b1, 12'h000, 1'b1);
    apply_stimulus(9'd403, 10'd30,  1'b0, 12'h333, 1'b1);
    apply_stimulus(9'd404, 10'd30,  1'b0, 12'hFFF, 1'b1);
    apply_stimulus(9'd401, 10'd1000, 1'b0, 12'h333, 1'b1);
    apply_stimulus(9'd400, 10'd700, 1'b0, 12'hFFF, 1'b1);

    // Inputs change mid-frame: pixels keep using the old snapshot
    dinosaur_height = 6'd10;
    ground_position = 6'd0;
    apply_stimulus(9'd380, 10'd64, 1'b0, 12'h555, 1'b1);
    apply_stimulus(9'd400, 10'd10, 1'b0, 12'hFFF, 1'b1);

    // Hold the latch address three cycles: one tick only
    push_tick(1, 1'b1);
    push_tick(2, 1'b0);
    push_tick(3, 1'b0);
    push_tick(4, 1'b0);
    apply_stimulus(9'd479, 10'd639, 1'b1, 12'h000, 1'b1);
    apply_stimulus(9'd479, 10'd639, 1'b1, 12'h000, 1'b1);
    apply_stimulus(9'd479, 10'd639, 1'b1, 12'h000, 1'b1);
    apply_stimulus(9'd380, 10'd64, 1'b0, 12'hFFF, 1'b1);
    apply_stimulus(9'd340, 10'd64, 1'b0, 12'h555, 1'b1);
    apply_stimulus(9'd339, 10'd64, 1'b0, 12'hFFF, 1'b1);
    apply_stimulus(9'd379, 10'd64, 1'b0, 12'h555, 1'b1);
    apply_stimulus(9'd400, 10'd10, 1'b0, 12'h333, 1'b1);

    // Reset asserted mid-frame while a tick and a sky pixel are on the outputs
    ground_position = 6'd40;
    apply_stimulus(9'd10,  10'd10,  1'b0, 12'hFFF, 1'b0);
    apply_stimulus(9'd479, 10'd639, 1'b0, 12'hFFF, 1'b0);
    check_output("pre_reset_data", vga_data, 12'hFFF);
    check_output("pre_reset_tick", {11'd0, frame_tick}, 12'h001);
    clrn = 1'b0;
    #1;
    check_output("midframe_reset_data", vga_data, 12'h000);
    check_output("midframe_reset_tick", {11'd0, frame_tick}, 12'h000);
    row_addr = 9'd0;
    col_addr = 10'd0;
    rdn      = 1'b1;
    #20 clrn = 1'b1;
    step();
    apply_stimulus(9'd380, 10'd64, 1'b0, 12'h555, 1'b1);
    apply_stimulus(9'd400, 10'd10, 1'b0, 12'h333, 1'b1);

    // Game over: blink phase flips every 16 frames
    game_status     = 1'b0;
    dinosaur_height = 6'd0;
    ground_position = 6'd0;
    for (int f = 1; f <= 20; f++) begin
      push_tick(1, 1'b1);
      apply_stimulus(9'd479, 10'd639, 1'b1, 12'h000, 1'b0);
      apply_stimulus(9'd380, 10'd64, 1'b0, ((f % 32) >= 16) ? 12'hF00 : 12'h555, 1'b1);
    end
    game_status = 1'b1;
    push_tick(1, 1'b1);
    apply_stimulus(9'd479, 10'd639, 1'b1, 12'h000, 1'b0);
    apply_stimulus(9'd380, 10'd64, 1'b0, 12'h555, 1'b1);
    game_status = 1'b0;
    for (int g = 1; g <= 33; g++) begin
      push_tick(1, 1'b1);
      apply_stimulus(9'd479, 10'd639, 1'b1, 12'h000, 1'b0);
      apply_stimulus(9'd380, 10'd64, 1'b0, ((g % 32) >= 16) ? 12'hF00 : 12'h555, 1'b1);
    end

    row_addr = 9'd0;
    col_addr = 10'd0;
    rdn      = 1'b1;
    for (int i = 0; i < 10 && (pix_q.size() > 0 || tick_q.size() > 0); i++) step();
    if (pix_q.size() > 0 || tick_q.size() > 0) begin
      chk_count++;
      err_count++;
      $display("[TB] FAIL drain: %0d pixel and %0d tick expectations left, expected 0",
               pix_q.size(), tick_q.size());
    end
    $display("Result: errors=%0d of %0d checks", err_count, chk_count);
    $finish;
  end

endmodule
